// File: rtl/draw_sched_pkg.sv
// -----------------------------------------------------------------------------
// draw_sched_pkg
// Shared definitions for the draw scheduler: requester count, field widths,
// the job counter width, the default job length and the scheduler FSM states.
// Also holds small index helpers used by the arbiter and the scheduler, so
// both agree on the requester numbering (0=press, 1=garbage, 2=aux).
// -----------------------------------------------------------------------------
package draw_sched_pkg;

    localparam int unsigned NREQ                = 3;
    localparam int unsigned POS_W               = 3;
    localparam int unsigned CNT_W               = 12;
    localparam int unsigned DRAW_CYCLES_DEFAULT = 2401;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Next requester index in round-robin order, wrapping 2 -> 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NREQ-1:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Only called on a valid one-hot value; anything else maps to 0.
    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Combinational three-way round-robin arbiter. The search starts at the
// requester after last_grant and wraps, so the most recently served
// requester has the lowest priority. The pointer itself lives in the caller.
//
// Ports
//   req         in  3  request levels
//   last_grant  in  2  index of the most recently granted requester
//   sel         out 3  one-hot winner, zero when req is zero
// -----------------------------------------------------------------------------
module rr_arbiter3
    import draw_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last_grant,
    output logic [NREQ-1:0] sel
);

    logic [1:0]      idx;
    logic [NREQ-1:0] cand;

    always_comb begin
        sel  = '0;
        cand = '0;
        idx  = next_idx(last_grant);
        for (int k = 0; k < NREQ; k++) begin
            cand = idx_to_onehot(idx);
            if ((sel == '0) && ((req & cand) != '0)) begin
                sel = cand;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
// Shares one draw engine between three requesters (press, garbage, aux).
// An idle scheduler picks a requester round-robin, latches its item, erase
// and position fields for the engine, pulses grant and draw_start, then
// counts DRAW_CYCLES cycles before pulsing done back to the owner.
//
// Timing of one job (cycle 0 = grant cycle):
//   cycles 0 .. DRAW_CYCLES-1  RUN, counter = cycle number
//   cycle  DRAW_CYCLES         DONE
//   cycle  DRAW_CYCLES+1       IDLE, done pulse visible (registered output);
//                              a request present here is granted next cycle.
//
// Ports
//   CLOCK_50    in   1  system clock
//   reset_n     in   1  asynchronous active-low reset
//   flush       in   1  abandon the current job (no done pulse)
//   req         in   3  per-requester request level
//   req_item    in   3  per-requester item select
//   req_erase   in   3  per-requester erase flag
//   req_pos     in   9  per-requester position, requester i at [3i+2:3i]
//   grant       out  3  one-hot pulse when a job is accepted
//   done        out  3  one-hot pulse when the granted job completes
//   item        out  1  latched item for the draw engine
//   erase       out  1  latched erase flag for the draw engine
//   position    out  3  latched position for the draw engine
//   draw_start  out  1  pulse starting the draw engine
//   busy        out  1  high while a job is in flight
// -----------------------------------------------------------------------------
module draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int unsigned DRAW_CYCLES = DRAW_CYCLES_DEFAULT
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_item,
    input  logic [NREQ-1:0]        req_erase,
    input  logic [NREQ*POS_W-1:0]  req_pos,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic                   item,
    output logic                   erase,
    output logic [POS_W-1:0]       position,
    output logic                   draw_start,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAW_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       last_grant_q;

    logic [NREQ-1:0]  sel;
    logic [1:0]       sel_idx;
    logic             sel_item;
    logic             sel_erase;
    logic [POS_W-1:0] sel_pos;

    rr_arbiter3 u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .sel        (sel)
    );

    assign sel_idx = onehot_to_idx(sel);

    // Fields of the winning requester, captured only on a grant.
    always_comb begin
        sel_item  = req_item[0];
        sel_erase = req_erase[0];
        sel_pos   = req_pos[POS_W-1:0];
        case (sel_idx)
            2'd1: begin
                sel_item  = req_item[1];
                sel_erase = req_erase[1];
                sel_pos   = req_pos[2*POS_W-1:POS_W];
            end
            2'd2: begin
                sel_item  = req_item[2];
                sel_erase = req_erase[2];
                sel_pos   = req_pos[3*POS_W-1:2*POS_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= 2'd2;  // requester 0 wins the first arbitration
            grant        <= '0;
            done         <= '0;
            draw_start   <= 1'b0;
            item         <= 1'b0;
            erase        <= 1'b0;
            position     <= '0;
        end else begin
            grant      <= '0;
            done       <= '0;
            draw_start <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req != '0) begin
                        grant        <= sel;
                        draw_start   <= 1'b1;
                        item         <= sel_item;
                        erase        <= sel_erase;
                        position     <= sel_pos;
                        last_grant_q <= sel_idx;
                        cnt_q        <= '0;
                        state_q      <= StRun;
                    end
                end
                StRun: begin
                    // flush beats terminal count
                    if (flush) begin
                        state_q <= StIdle;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    if (!flush) begin
                        done <= idx_to_onehot(last_grant_q);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

    localparam int D    = 4;
    localparam int DBIG = 2401;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       flush    = 1'b0;
    logic [2:0] req      = '0;
    logic [2:0] req_item = '0;
    logic [2:0] req_erase = '0;
    logic [8:0] req_pos  = '0;

    logic [2:0] grant, done, position;
    logic       item, erase, draw_start, busy;
    logic [2:0] big_grant, big_done, big_position;
    logic       big_item, big_erase, big_draw_start, big_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: a job is tracked by its age in cycles since grant.
    int         m_age  = -1;
    int         m_last = 2;
    logic [2:0] e_grant, e_done, e_pos;
    logic       e_item, e_erase;

    always #10 CLOCK_50 = ~CLOCK_50;

    draw_scheduler #(.DRAW_CYCLES(D)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .flush      (flush),
        .req        (req),
        .req_item   (req_item),
        .req_erase  (req_erase),
        .req_pos    (req_pos),
        .grant      (grant),
        .done       (done),
        .item       (item),
        .erase      (erase),
        .position   (position),
        .draw_start (draw_start),
        .busy       (busy)
    );

    draw_scheduler #(.DRAW_CYCLES(DBIG)) dut_big (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .flush      (flush),
        .req        (req),
        .req_item   (req_item),
        .req_erase  (req_erase),
        .req_pos    (req_pos),
        .grant      (big_grant),
        .done       (big_done),
        .item       (big_item),
        .erase      (big_erase),
        .position   (big_position),
        .draw_start (big_draw_start),
        .busy       (big_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_age   = -1;
        m_last  = 2;
        e_grant = '0;
        e_done  = '0;
        e_item  = 1'b0;
        e_erase = 1'b0;
        e_pos   = '0;
    endtask

    // Advance the model across one clock edge using the inputs about to be sampled.
    task automatic model_edge();
        int win;
        e_grant = '0;
        e_done  = '0;
        if (m_age >= 0) begin
            if (flush) begin
                m_age = -1;
            end else if (m_age == D) begin
                m_age  = -1;
                e_done = 3'(1 << m_last);
            end else begin
                m_age++;
            end
        end else if (req != 3'b000) begin
            win = -1;
            for (int k = 1; k <= 3; k++) begin
                if (win < 0 && req[(m_last + k) % 3]) win = (m_last + k) % 3;
            end
            m_last  = win;
            e_grant = 3'(1 << win);
            e_item  = req_item[win];
            e_erase = req_erase[win];
            e_pos   = req_pos[3*win +: 3];
            m_age   = 0;
        end
    endtask

    task automatic check_all();
        chk("grant", 32'(grant), 32'(e_grant));
        chk("done", 32'(done), 32'(e_done));
        chk("draw_start", 32'(draw_start), 32'(e_grant != 3'b000));
        chk("busy", 32'(busy), 32'(m_age >= 0));
        chk("item", 32'(item), 32'(e_item));
        chk("erase", 32'(erase), 32'(e_erase));
        chk("position", 32'(position), 32'(e_pos));
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLOCK_50);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("big_busy_rst", 32'(big_busy), 32'd0);
        @(posedge CLOCK_50);
        #1;
        check_all();
        reset_n = 1'b1;
    endtask

    logic [2:0] seq[$];
    logic       saw_g1;
    int         n;
    bit         seen_done;

    initial begin
        model_reset();
        @(posedge CLOCK_50);
        #1;
        do_reset();

        // Single request: pos 5, erase 1, done 5 cycles after grant.
        req = 3'b001; req_pos = 9'o005; req_erase = 3'b001; req_item = 3'b000;
        tick();
        chk("single_grant", 32'(grant), 32'b001);
        req = '0; req_pos = 9'o777; req_erase = 3'b000; req_item = 3'b111;
        for (int c = 1; c <= D + 1; c++) begin
            tick();
            chk("single_pos_held", 32'(position), 32'd5);
        end
        chk("single_done_lat", 32'(done), 32'b001);

        // Contention: all three held continuously.
        do_reset();
        req = 3'b111; req_pos = 9'o123; req_item = 3'b101; req_erase = 3'b010;
        for (int c = 0; c < 4 * (D + 2); c++) begin
            tick();
            if (grant != 3'b000) seq.push_back(grant);
        end
        chk("rot_len_ge4", 32'(seq.size() >= 4), 32'd1);
        if (seq.size() >= 4) begin
            chk("rot0", 32'(seq[0]), 32'b001);
            chk("rot1", 32'(seq[1]), 32'b010);
            chk("rot2", 32'(seq[2]), 32'b100);
            chk("rot3", 32'(seq[3]), 32'b001);
        end
        req = '0;
        repeat (D + 3) tick();

        // Withdrawal: req[1] pulsed once while busy with requester 0.
        do_reset();
        saw_g1 = 1'b0;
        req = 3'b001;
        tick();
        req = 3'b010;
        tick();
        req = 3'b000;
        for (int c = 0; c < D + 4; c++) begin
            tick();
            if (grant[1]) saw_g1 = 1'b1;
        end
        chk("withdraw_no_g1", 32'(saw_g1), 32'd0);

        // Flush two cycles after grant.
        do_reset();
        req = 3'b001;
        tick();
        req = 3'b000;
        tick();
        tick();
        flush = 1'b1;
        tick();
        chk("flush_busy", 32'(busy), 32'd0);
        flush = 1'b0;
        req = 3'b010;
        tick();
        chk("flush_next_grant", 32'(grant), 32'b010);
        req = 3'b000;
        repeat (D + 3) tick();

        // Reset in the middle of a job.
        req = 3'b100;
        tick();
        tick();
        req = 3'b000;
        do_reset();
        req = 3'b111;
        tick();
        chk("rst_first_grant", 32'(grant), 32'b001);
        req = 3'b000;
        repeat (D + 3) tick();

        // Randomized traffic with withdrawals and occasional flushes.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i]          = 1'b1;
                        req_item[i]     = 1'($urandom_range(0, 1));
                        req_erase[i]    = 1'($urandom_range(0, 1));
                        req_pos[3*i+:3] = 3'($urandom_range(0, 7));
                    end
                end else if (e_grant[i] && $urandom_range(0, 1) == 0) begin
                    req[i]          = 1'b0;
                    req_pos[3*i+:3] = 3'($urandom_range(0, 7));
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        req = 3'b000;
        repeat (D + 3) tick();

        // Terminal count with the default job length.
        do_reset();
        req = 3'b001;
        tick();
        chk("big_grant", 32'(big_grant), 32'b001);
        req = 3'b000;
        n = 0;
        seen_done = 1'b0;
        while (!seen_done && n < DBIG + 50) begin
            tick();
            n++;
            if (big_done != 3'b000) seen_done = 1'b1;
            else if (n == DBIG) chk("big_busy_last", 32'(big_busy), 32'd1);
        end
        chk("big_done_seen", 32'(seen_done), 32'd1);
        chk("big_done_lat", 32'(n), 32'(DBIG + 1));
        chk("big_done_val", 32'(big_done), 32'b001);
        chk("big_busy_after", 32'(big_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
